// File: rtl/brtgt_pipe_pkg.sv
// Shared decode constants for the branch-target pipeline.
// Opcode values, lane kind encodings and immediate extraction.
package brtgt_pipe_pkg;

    localparam logic [6:0] RV32_BRANCH = 7'b1100011;
    localparam logic [6:0] RV32_JAL    = 7'b1101111;
    localparam logic [6:0] RV32_JALR   = 7'b1100111;

    localparam int IMM_RAW_W = 21;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JAL    = 2'd2,
        KIND_JALR   = 2'd3
    } kind_e;

    // 21-bit signed immediate; the widest (JAL) format sets the width.
    function automatic logic [IMM_RAW_W-1:0] imm_raw(
        input logic [31:0] inst,
        input kind_e       kind
    );
        logic [IMM_RAW_W-1:0] r;
        r = '0;
        case (kind)
            KIND_BRANCH: r = {{8{inst[31]}}, inst[31], inst[7],
                              inst[30:25], inst[11:8], 1'b0};
            KIND_JAL:    r = {inst[31], inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            KIND_JALR:   r = {{9{inst[31]}}, inst[31:20]};
            default:     r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/brtgt_pipe_lane.sv
// One decode lane: immediate, target, kind and check flags.
// Purely combinational; invalid lanes produce all zeros.
module brtgt_lane
    import brtgt_pipe_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int INSN_LEN = 32
) (
    input  logic [INSN_LEN-1:0] inst,
    input  logic [ADDR_LEN-1:0] pc,
    input  logic [DATA_LEN-1:0] rs1,
    input  logic [ADDR_LEN-1:0] pred_tgt,
    input  logic                lane_vld,
    output logic [1:0]          kind,
    output logic [DATA_LEN-1:0] imm,
    output logic [ADDR_LEN-1:0] tgt,
    output logic                misalign,
    output logic                mismatch
);

    kind_e                kind_d;
    logic [IMM_RAW_W-1:0] raw;
    logic [DATA_LEN-1:0]  imm_d;
    logic [ADDR_LEN-1:0]  imm_a;
    logic [ADDR_LEN-1:0]  rs1_a;
    logic [ADDR_LEN-1:0]  base;
    logic [ADDR_LEN-1:0]  sum;

    // Classify the lane from its opcode; masked lanes are never transfers.
    always_comb begin
        kind_d = KIND_NONE;
        if (lane_vld) begin
            case (inst[6:0])
                RV32_BRANCH: kind_d = KIND_BRANCH;
                RV32_JAL:    kind_d = KIND_JAL;
                RV32_JALR:   kind_d = KIND_JALR;
                default:     kind_d = KIND_NONE;
            endcase
        end
    end

    assign raw   = imm_raw(inst[31:0], kind_d);
    assign imm_d = {{(DATA_LEN-IMM_RAW_W){raw[IMM_RAW_W-1]}}, raw};
    assign imm_a = {{(ADDR_LEN-IMM_RAW_W){raw[IMM_RAW_W-1]}}, raw};

    if (DATA_LEN >= ADDR_LEN) begin : g_rs1_trunc
        assign rs1_a = rs1[ADDR_LEN-1:0];
    end else begin : g_rs1_ext
        assign rs1_a = {{(ADDR_LEN-DATA_LEN){1'b0}}, rs1};
    end

    assign base = (kind_d == KIND_JALR) ? rs1_a : pc;
    assign sum  = base + imm_a;

    // Drive lane results; everything stays zero for non-transfer lanes.
    always_comb begin
        kind     = kind_d;
        imm      = '0;
        tgt      = '0;
        misalign = 1'b0;
        mismatch = 1'b0;
        if (kind_d != KIND_NONE) begin
            imm = imm_d;
            tgt = sum;
            if (kind_d == KIND_JALR) begin
                tgt[0] = 1'b0;
            end
            misalign = tgt[1];
            mismatch = (pred_tgt != tgt);
        end
    end

endmodule

// File: rtl/brtgt_pipe.sv
// Multi-lane branch-target stage with 1-cycle latency.
// Main register plus one skid entry keep in_ready registered.
module brtgt_pipe
    import brtgt_pipe_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32,
    parameter int INSN_LEN = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_vld,
    input  logic [LANES*INSN_LEN-1:0] in_inst,
    input  logic [LANES*ADDR_LEN-1:0] in_pc,
    input  logic [LANES*DATA_LEN-1:0] in_rs1,
    input  logic [LANES*ADDR_LEN-1:0] in_pred_tgt,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_vld,
    output logic [LANES*2-1:0]        out_kind,
    output logic [LANES*DATA_LEN-1:0] out_imm,
    output logic [LANES*ADDR_LEN-1:0] out_tgt,
    output logic [LANES-1:0]          out_misalign,
    output logic [LANES-1:0]          out_mismatch
);

    typedef struct packed {
        logic [LANES-1:0]          lv;
        logic [LANES*2-1:0]        kind;
        logic [LANES*DATA_LEN-1:0] imm;
        logic [LANES*ADDR_LEN-1:0] tgt;
        logic [LANES-1:0]          mis;
        logic [LANES-1:0]          mm;
    } grp_t;

    grp_t new_g;
    grp_t main_q;
    grp_t skid_q;
    logic main_vld;
    logic skid_vld;
    logic accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        brtgt_lane #(
            .DATA_LEN (DATA_LEN),
            .ADDR_LEN (ADDR_LEN),
            .INSN_LEN (INSN_LEN)
        ) u_lane (
            .inst     (in_inst[i*INSN_LEN +: INSN_LEN]),
            .pc       (in_pc[i*ADDR_LEN +: ADDR_LEN]),
            .rs1      (in_rs1[i*DATA_LEN +: DATA_LEN]),
            .pred_tgt (in_pred_tgt[i*ADDR_LEN +: ADDR_LEN]),
            .lane_vld (in_lane_vld[i]),
            .kind     (new_g.kind[i*2 +: 2]),
            .imm      (new_g.imm[i*DATA_LEN +: DATA_LEN]),
            .tgt      (new_g.tgt[i*ADDR_LEN +: ADDR_LEN]),
            .misalign (new_g.mis[i]),
            .mismatch (new_g.mm[i])
        );
    end

    assign new_g.lv = in_lane_vld;

    // Ready only reflects skid occupancy; reset forces it low immediately.
    assign in_ready = reset & ~skid_vld;
    assign accept   = in_valid & in_ready & ~flush;

    // Main/skid occupancy and data; flush beats both accept and drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_ready) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                main_vld <= accept;
                if (accept) begin
                    main_q <= new_g;
                end
            end
        end else if (accept) begin
            skid_q   <= new_g;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid    = main_vld;
    assign out_lane_vld = main_q.lv;
    assign out_kind     = main_q.kind;
    assign out_imm      = main_q.imm;
    assign out_tgt      = main_q.tgt;
    assign out_misalign = main_q.mis;
    assign out_mismatch = main_q.mm;

endmodule

// File: tb/tb_brtgt_pipe.sv
// Self-checking bench for brtgt_pipe with a queue-based model.
// Directed groups cover decode, wrap, backpressure, flush and reset.
module tb_brtgt_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_lane_vld;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_rs1;
    logic [63:0] in_pred_tgt;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane_vld;
    logic [3:0]  out_kind;
    logic [63:0] out_imm;
    logic [63:0] out_tgt;
    logic [1:0]  out_misalign;
    logic [1:0]  out_mismatch;

    always #5 clk = ~clk;

    brtgt_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lane_vld  (in_lane_vld),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_rs1       (in_rs1),
        .in_pred_tgt  (in_pred_tgt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_lane_vld (out_lane_vld),
        .out_kind     (out_kind),
        .out_imm      (out_imm),
        .out_tgt      (out_tgt),
        .out_misalign (out_misalign),
        .out_mismatch (out_mismatch)
    );

    typedef struct {
        logic [1:0]  lv;
        logic [3:0]  kind;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [1:0]  mis;
        logic [1:0]  mm;
    } grp_t;

    grp_t q[$];
    int   nchk  = 0;
    int   nerr  = 0;
    bit   armed = 1'b0;
    bit   zexp  = 1'b0;

    logic [31:0] tbl [8] = '{
        32'hFE000EE3, 32'h001000EF, 32'h00328067, 32'h800000EF,
        32'h7FF00067, 32'h00208463, 32'h00000013, 32'h80000E63
    };

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural meaning of one lane, using signed integer offsets.
    function automatic void lane_model(
        input  logic [31:0] inst, pc, rs1, pred,
        input  logic        v,
        output logic [1:0]  k,
        output logic [31:0] imm, tgt,
        output logic        mis, mm
    );
        longint off;
        longint base;
        longint s;
        k = 2'd0; imm = '0; tgt = '0; mis = 1'b0; mm = 1'b0;
        off = 0;
        base = 64'(pc);
        if (!v) return;
        case (inst[6:0])
            7'h63: begin
                k = 2'd1;
                off = 64'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
                if (inst[31]) off = off - 8192;
            end
            7'h6F: begin
                k = 2'd2;
                off = 64'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
                if (inst[31]) off = off - 2097152;
            end
            7'h67: begin
                k = 2'd3;
                off = 64'(inst[31:20]);
                if (inst[31]) off = off - 4096;
                base = 64'(rs1);
            end
            default: return;
        endcase
        s = base + off;
        imm = off[31:0];
        tgt = s[31:0];
        if (k == 2'd3) tgt[0] = 1'b0;
        mis = tgt[1];
        mm = (tgt != pred);
    endfunction

    function automatic grp_t group_model();
        grp_t g;
        logic [1:0]  k;
        logic [31:0] im, tg;
        logic        mi, m;
        g.lv = in_lane_vld;
        g.kind = '0; g.imm = '0; g.tgt = '0; g.mis = '0; g.mm = '0;
        for (int i = 0; i < 2; i++) begin
            lane_model(in_inst[i*32 +: 32], in_pc[i*32 +: 32],
                       in_rs1[i*32 +: 32], in_pred_tgt[i*32 +: 32],
                       in_lane_vld[i], k, im, tg, mi, m);
            g.kind[i*2 +: 2] = k;
            g.imm[i*32 +: 32] = im;
            g.tgt[i*32 +: 32] = tg;
            g.mis[i] = mi;
            g.mm[i] = m;
        end
        return g;
    endfunction

    // Compare outputs mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        bit rdy;
        if (armed) begin
            chk("in_ready", 64'(in_ready), 64'(reset && q.size() < 2));
            if (q.size() != 0) begin
                chk("out_valid", 64'(out_valid), 64'd1);
                chk("lane_vld", 64'(out_lane_vld), 64'(q[0].lv));
                chk("kind", 64'(out_kind), 64'(q[0].kind));
                chk("imm", out_imm, q[0].imm);
                chk("tgt", out_tgt, q[0].tgt);
                chk("misalign", 64'(out_misalign), 64'(q[0].mis));
                chk("mismatch", 64'(out_mismatch), 64'(q[0].mm));
            end else begin
                chk("out_valid_idle", 64'(out_valid), 64'd0);
                if (zexp) begin
                    chk("rst_imm", out_imm, 64'd0);
                    chk("rst_tgt", out_tgt, 64'd0);
                    chk("rst_flags",
                        64'({out_lane_vld, out_kind, out_misalign, out_mismatch}),
                        64'd0);
                end
            end
        end
        if (!reset) begin
            q.delete();
            zexp = 1'b1;
            armed = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            rdy = (q.size() < 2);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                q.push_back(group_model());
                zexp = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [31:0] inst, pc, rs1, pred);
        in_inst[i*32 +: 32] = inst;
        in_pc[i*32 +: 32] = pc;
        in_rs1[i*32 +: 32] = rs1;
        in_pred_tgt[i*32 +: 32] = pred;
    endtask

    task automatic load_tbl(input int k);
        in_lane_vld = 2'(k % 4);
        set_lane(0, tbl[k % 8], 32'h1000 + 32'(k * 8),
                 32'(k) * 32'h12345671, 32'h1004 + 32'(k * 8));
        set_lane(1, tbl[(k + 3) % 8], 32'h2000 + 32'(k * 8),
                 32'hFFFFFFF0 - 32'(k), 32'h2004);
    endtask

    // Hold the group until it is taken, with a bounded wait.
    task automatic offer();
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        nchk++;
        nerr++;
        $display("FAIL offer_timeout: got in_ready=0 expected acceptance within 20 cycles");
        in_valid = 1'b0;
    endtask

    initial begin
        logic [1:0]  k;
        logic [31:0] im, tg;
        logic        mi, m;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_lane_vld = '0; in_inst = '0; in_pc = '0; in_rs1 = '0; in_pred_tgt = '0;

        lane_model(32'hFE000EE3, 32'h100, 32'h0, 32'hFC, 1'b1, k, im, tg, mi, m);
        chk("pin_beq", {k, im, tg, mi, m}, {2'd1, 32'hFFFFFFFC, 32'hFC, 1'b0, 1'b0});
        lane_model(32'h001000EF, 32'h1000, 32'h0, 32'h1004, 1'b1, k, im, tg, mi, m);
        chk("pin_jal", {k, im, tg, mi, m}, {2'd2, 32'h800, 32'h1800, 1'b0, 1'b1});
        lane_model(32'h00328067, 32'h0, 32'h2000, 32'h2002, 1'b1, k, im, tg, mi, m);
        chk("pin_jalr", {k, im, tg, mi, m}, {2'd3, 32'h3, 32'h2002, 1'b1, 1'b0});
        lane_model(32'h00328067, 32'h0, 32'hFFFFFFFE, 32'h0, 1'b1, k, im, tg, mi, m);
        chk("pin_wrap", {k, im, tg, mi, m}, {2'd3, 32'h3, 32'h0, 1'b0, 1'b0});
        lane_model(32'h001000EF, 32'h1000, 32'h0, 32'h1, 1'b0, k, im, tg, mi, m);
        chk("pin_masked", {k, im, tg, mi, m}, 64'd0);

        tick(); tick();
        reset = 1'b1;
        tick();

        in_lane_vld = 2'b01;
        set_lane(0, 32'hFE000EE3, 32'h100, 32'h0, 32'hFC);
        set_lane(1, 32'h001000EF, 32'h1000, 32'h0, 32'h1004);
        offer(); tick(); tick();

        in_lane_vld = 2'b11;
        set_lane(0, 32'h00328067, 32'h40, 32'h2000, 32'h2002);
        offer();
        set_lane(0, 32'h00328067, 32'h40, 32'hFFFFFFFE, 32'h0);
        set_lane(1, 32'h00100093, 32'h44, 32'h5, 32'h48);
        offer(); tick(); tick();

        out_ready = 1'b0;
        load_tbl(1); offer();
        load_tbl(2); offer();
        load_tbl(3); in_valid = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b1;
        offer(); tick(); tick(); tick();

        out_ready = 1'b0;
        load_tbl(5); offer();
        load_tbl(6); offer();
        load_tbl(7); in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        load_tbl(9); out_ready = 1'b1;
        offer(); tick(); tick();

        out_ready = 1'b0;
        load_tbl(10); offer();
        load_tbl(11); offer();
        load_tbl(12); in_valid = 1'b1; reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        tick(); tick();

        for (int i = 0; i < 12; i++) begin
            load_tbl(i + 13);
            out_ready = (i % 3 != 1);
            offer();
        end
        out_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/brtgt_pipe.md
Name: brtgt_pipe

Overview:
- Parametrised, multi-lane successor to the combinational branch-immediate generator.
- For each decode lane it:
  - extracts the B/J/JALR immediate,
  - computes the control-transfer target (PC-relative, or rs1-relative for JALR),
  - classifies the instruction,
  - flags misalignment and mismatch against the fetch-predicted target.
- Sits between decode and the branch unit / redirect logic.
- Registered, 1-cycle latency, valid/ready handshake, 2-entry skid so input ready is registered.

Parameters:
- LANES, 2, decode lanes processed per group
- DATA_LEN, 32, immediate/operand width (sign-extension target)
- ADDR_LEN, 32, PC/target width
- INSN_LEN, 32, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  discard all buffered groups
- in_valid  in  1  group offered
- in_ready  out  1  group accepted when in_valid & in_ready
- in_lane_vld  in  LANES  per-lane valid within group
- in_inst  in  LANES*INSN_LEN  instructions, lane 0 in LSBs
- in_pc  in  LANES*ADDR_LEN  lane PCs
- in_rs1  in  LANES*DATA_LEN  rs1 value (used by JALR only)
- in_pred_tgt  in  LANES*ADDR_LEN  fetch-predicted target
- out_valid  out  1  group available
- out_ready  in  1  consumer accepts
- out_lane_vld  out  LANES  echoed lane valid
- out_kind  out  LANES*2  per lane: 0 none, 1 BRANCH, 2 JAL, 3 JALR
- out_imm  out  LANES*DATA_LEN  sign-extended immediate
- out_tgt  out  LANES*ADDR_LEN  computed target
- out_misalign  out  LANES  target[1] set on a kind≠0 lane
- out_mismatch  out  LANES  kind≠0 and in_pred_tgt ≠ out_tgt

Behaviour:
- Reset (reset==0 at posedge): main and skid entries invalid; out_valid=0, all out_* data=0.
  - in_ready is driven 0 while reset is asserted and 1 in the first cycle after release.
  - Reset mid-transfer drops all held groups.
- Immediates, decoded from opcode inst[6:0]:
  - BRANCH: {sext inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - JAL: {sext inst[31], inst[19:12], inst[20], inst[30:25], inst[24:21], 0}.
  - JALR: {sext inst[31], inst[30:20]}.
  - Any other opcode: kind 0, imm 0, tgt 0, flags 0.
- Targets:
  - BRANCH/JAL: tgt = pc + imm.
  - JALR: tgt = (rs1 + imm) with bit 0 cleared.
  - Arithmetic is modulo 2^ADDR_LEN; wrap-around is not flagged.
  - imm is truncated or sign-extended to ADDR_LEN before the add.
- Lanes with in_lane_vld=0 are forced to kind 0, all data and flags 0, regardless of inst.
- Pipeline:
  - Accepted group appears on out_* the cycle after acceptance (latency 1).
  - Throughput is 1 group/cycle while out_ready=1.
- Skid buffer:
  - in_ready = skid entry empty (registered).
  - If the main entry is valid and out_ready=0, an accepted group goes to the skid, and in_ready falls next cycle.
  - When the main entry drains, the skid moves to main.
  - Order is strictly preserved; no group is lost or duplicated.
  - Output data is stable while out_valid & !out_ready.
- flush:
  - Both entries invalidated at the next edge; out_valid=0 the following cycle.
  - A group presented with in_valid in the flush cycle is dropped, even if in_ready=1.
  - Flush takes priority over acceptance and drain.
  - in_ready=1 the cycle after flush.
- Simultaneous out_ready and in_valid with main full and skid empty: main drains, new group enters main; skid stays empty.

Decomposition:
- Opcode constants (RV32_BRANCH, RV32_JAL, RV32_JALR) and the kind encodings belong in the shared headers (rv32_opcodes.vh, constants.vh).
- Natural sub-module: brtgt_lane.
  - Purely combinational.
  - Inputs: one lane's inst, pc, rs1, pred_tgt, lane_vld.
  - Outputs: kind, imm, tgt, misalign, mismatch.
  - Instantiated LANES times with generate.
- The top level holds only the main/skid registers and handshake.

Test Plan:
- Lane0 inst=0xFE000EE3 (beq x0,x0,-4), pc=0x100, pred=0xFC, lane_vld=01, out_ready=1 -> next cycle out_valid=1, kind0=1, imm0=0xFFFFFFFC, tgt0=0xFC, mismatch0=0, misalign0=0; lane1 all zero.
- Lane1 inst=0x001000EF (jal x1,+2048), pc=0x1000, pred=0x1004 -> kind1=2, imm1=0x800, tgt1=0x1800, mismatch1=1.
- inst=0x00328067 (jalr x0,3(x5)), rs1=0x2000 -> kind=3, imm=3, tgt=0x2002, misalign=1. Same with rs1=0xFFFFFFFE and imm=3 -> tgt=0x00000000 (wrap, bit0 cleared), no error.
- Backpressure: out_ready=0, offer groups A,B,C on consecutive cycles -> A held in main, B in skid, in_ready=0 so C waits. Raise out_ready -> outputs A,B,C on consecutive cycles, no gaps or duplicates.
- Flush with main and skid full plus in_valid=1 -> out_valid=0 next cycle, offered group dropped, in_ready=1; next accepted group D emerges alone.
- Assert reset for 1 cycle with main and skid full -> out_valid=0, outputs 0. in_ready=0 during reset, 1 after release.
